// File: rtl/cmac_approx_pkg.sv
// Shared constants and saturation helpers for the approximate CMAC accumulation stage.
package cmac_approx_pkg;

    localparam int NUM_MUL_DEF = 8;
    localparam int PROD_W_DEF  = 32;
    localparam int ACC_W_DEF   = 48;
    localparam int BEAT_W_DEF  = 8;

    // Helpers return a 64-bit container; callers slice to their ACC_W (<= 64).
    localparam int SAT_CW = 64;

    // Largest positive signed value representable in w bits.
    function automatic logic [SAT_CW-1:0] sat_max(input int w);
        sat_max = (SAT_CW'(1) << (w - 1)) - SAT_CW'(1);
    endfunction

    // Most negative signed value in w bits (only the low w bits are meaningful).
    function automatic logic [SAT_CW-1:0] sat_min(input int w);
        sat_min = SAT_CW'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/cmac_approx_acc16_if.sv
// Beat input / result output bundle between the multiplier array, this stage and CACC.
interface cmac_approx_acc16_if
    import cmac_approx_pkg::*;
#(
    parameter int NUM_MUL = NUM_MUL_DEF,
    parameter int PROD_W  = PROD_W_DEF,
    parameter int ACC_W   = ACC_W_DEF,
    parameter int BEAT_W  = BEAT_W_DEF
);
    logic                        in_valid;
    logic                        in_ready;
    logic [NUM_MUL*PROD_W-1:0]   in_data;
    logic [NUM_MUL-1:0]          in_mask;
    logic                        in_last;
    logic                        out_valid;
    logic                        out_ready;
    logic [ACC_W-1:0]            out_data;
    logic                        out_sat;
    logic [BEAT_W-1:0]           out_beats;

    modport master (
        output in_valid, in_data, in_mask, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_sat, out_beats
    );

    modport slave (
        input  in_valid, in_data, in_mask, in_last, out_ready,
        output in_ready, out_valid, out_data, out_sat, out_beats
    );
endinterface

// File: rtl/cmac_acc_adder_tree.sv
// Combinational masked reduction of NUM_MUL signed products into one
// PROD_W+log2(NUM_MUL) bit sum; wide enough that it can never overflow.
module cmac_acc_adder_tree #(
    parameter int NUM_MUL = 8,
    parameter int PROD_W  = 32,
    localparam int LVL    = $clog2(NUM_MUL),
    localparam int SUM_W  = PROD_W + LVL
) (
    input  logic [NUM_MUL*PROD_W-1:0] data,
    input  logic [NUM_MUL-1:0]        mask,
    output logic signed [SUM_W-1:0]   sum
);

    // Level 0 holds masked, sign-extended leaves; each later level halves the count.
    for (genvar l = 0; l <= LVL; l++) begin : g_lvl
        localparam int N = NUM_MUL >> l;
        logic signed [SUM_W-1:0] v [N];
        for (genvar i = 0; i < N; i++) begin : g_n
            if (l == 0) begin : g_leaf
                assign v[i] = mask[i] ? SUM_W'($signed(data[i*PROD_W +: PROD_W])) : '0;
            end else begin : g_add
                assign v[i] = g_lvl[l-1].v[2*i] + g_lvl[l-1].v[2*i+1];
            end
        end
    end

    assign sum = g_lvl[LVL].v[0];

endmodule

// File: rtl/cmac_approx_acc16.sv
// Accumulation stage: masked adder tree -> stage-1 register -> saturating
// accumulator -> output register. One global advance stalls the whole pipe
// when a result is waiting and CACC is not ready.
module cmac_approx_acc16
    import cmac_approx_pkg::*;
#(
    parameter int NUM_MUL = NUM_MUL_DEF,
    parameter int PROD_W  = PROD_W_DEF,
    parameter int ACC_W   = ACC_W_DEF,
    parameter int BEAT_W  = BEAT_W_DEF
) (
    input  logic                nvdla_core_clk,
    input  logic                nvdla_core_rstn,
    cmac_approx_acc16_if.slave  bus
);

    localparam int SUM_W = PROD_W + $clog2(NUM_MUL);
    localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'(sat_max(ACC_W));
    localparam logic [ACC_W-1:0] SAT_MIN = ACC_W'(sat_min(ACC_W));

    logic                     rdy_en_q, rdy_en_d;
    logic                     s1_vld_q, s1_vld_d;
    logic                     s1_last_q, s1_last_d;
    logic signed [SUM_W-1:0]  s1_sum_q, s1_sum_d;
    logic [ACC_W-1:0]         acc_q, acc_d;
    logic [BEAT_W-1:0]        cnt_q, cnt_d;
    logic                     sticky_q, sticky_d;
    logic                     out_valid_q, out_valid_d;
    logic [ACC_W-1:0]         out_data_q, out_data_d;
    logic                     out_sat_q, out_sat_d;
    logic [BEAT_W-1:0]        out_beats_q, out_beats_d;

    logic                     adv;
    logic signed [SUM_W-1:0]  tree_sum;
    logic signed [ACC_W:0]    nxt_w;
    logic                     ovf;
    logic [ACC_W-1:0]         nxt;
    logic [BEAT_W-1:0]        cnt_inc;

    cmac_acc_adder_tree #(
        .NUM_MUL (NUM_MUL),
        .PROD_W  (PROD_W)
    ) u_tree (
        .data (bus.in_data),
        .mask (bus.in_mask),
        .sum  (tree_sum)
    );

    // rdy_en_q keeps in_ready low while reset is asserted and until the first edge after.
    assign adv          = !out_valid_q || bus.out_ready;
    assign bus.in_ready = rdy_en_q && adv;

    // Accumulate one extra bit so overflow shows up as a sign-bit disagreement.
    assign nxt_w   = $signed({acc_q[ACC_W-1], acc_q}) + (ACC_W+1)'(s1_sum_q);
    assign ovf     = nxt_w[ACC_W] ^ nxt_w[ACC_W-1];
    assign nxt     = ovf ? (nxt_w[ACC_W] ? SAT_MIN : SAT_MAX) : nxt_w[ACC_W-1:0];
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    // Next-state for both pipeline stages; everything holds when adv is low.
    always_comb begin
        rdy_en_d    = 1'b1;
        s1_vld_d    = s1_vld_q;
        s1_last_d   = s1_last_q;
        s1_sum_d    = s1_sum_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sticky_d    = sticky_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        out_beats_d = out_beats_q;

        if (adv) begin
            s1_vld_d  = bus.in_valid && rdy_en_q;
            s1_last_d = bus.in_last;
            s1_sum_d  = tree_sum;

            if (s1_vld_q && s1_last_q) begin
                out_valid_d = 1'b1;
                out_data_d  = nxt;
                out_sat_d   = sticky_q || ovf;
                out_beats_d = cnt_inc;
                acc_d       = '0;
                cnt_d       = '0;
                sticky_d    = 1'b0;
            end else begin
                // adv with out_valid high implies out_ready: the result was taken.
                out_valid_d = 1'b0;
                if (s1_vld_q) begin
                    acc_d    = nxt;
                    cnt_d    = cnt_inc;
                    sticky_d = sticky_q || ovf;
                end
            end
        end
    end

    // State registers; async reset discards any partial dot product.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            rdy_en_q    <= 1'b0;
            s1_vld_q    <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_sum_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            sticky_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            out_beats_q <= '0;
        end else begin
            rdy_en_q    <= rdy_en_d;
            s1_vld_q    <= s1_vld_d;
            s1_last_q   <= s1_last_d;
            s1_sum_q    <= s1_sum_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sticky_q    <= sticky_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            out_beats_q <= out_beats_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sat   = out_sat_q;
    assign bus.out_beats = out_beats_q;

endmodule

// File: tb/tb_cmac_approx_acc16.sv
// Directed bench for cmac_approx_acc16: a default 48-bit instance plus a
// 36-bit instance used for the saturation case.
module tb_cmac_approx_acc16;

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    cmac_approx_acc16_if #(.NUM_MUL(8), .PROD_W(32), .ACC_W(48), .BEAT_W(8)) u_if48 ();
    cmac_approx_acc16_if #(.NUM_MUL(8), .PROD_W(32), .ACC_W(36), .BEAT_W(8)) u_if36 ();

    cmac_approx_acc16 #(.NUM_MUL(8), .PROD_W(32), .ACC_W(48), .BEAT_W(8)) u_dut48 (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rst_n),
        .bus             (u_if48.slave)
    );

    cmac_approx_acc16 #(.NUM_MUL(8), .PROD_W(32), .ACC_W(36), .BEAT_W(8)) u_dut36 (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rst_n),
        .bus             (u_if36.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock; inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        assert (act === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    // Present one beat with every product equal to p on the 48-bit instance.
    task automatic beat48(input logic [31:0] p, input logic [7:0] m, input logic last);
        for (int i = 0; i < 8; i++) u_if48.in_data[i*32 +: 32] = p;
        u_if48.in_mask  = m;
        u_if48.in_last  = last;
        u_if48.in_valid = 1'b1;
    endtask

    task automatic beat36(input logic [31:0] p, input logic [7:0] m, input logic last);
        for (int i = 0; i < 8; i++) u_if36.in_data[i*32 +: 32] = p;
        u_if36.in_mask  = m;
        u_if36.in_last  = last;
        u_if36.in_valid = 1'b1;
    endtask

    initial begin
        rst_n            = 1'b0;
        u_if48.in_valid  = 1'b0;
        u_if48.in_data   = '0;
        u_if48.in_mask   = '0;
        u_if48.in_last   = 1'b0;
        u_if48.out_ready = 1'b1;
        u_if36.in_valid  = 1'b0;
        u_if36.in_data   = '0;
        u_if36.in_mask   = '0;
        u_if36.in_last   = 1'b0;
        u_if36.out_ready = 1'b1;

        // Reset state
        step();
        step();
        check("rst_in_ready",  64'(u_if48.in_ready),  64'd0);
        check("rst_out_valid", 64'(u_if48.out_valid), 64'd0);
        check("rst_out_data",  64'(u_if48.out_data),  64'd0);
        check("rst_out_sat",   64'(u_if48.out_sat),   64'd0);
        check("rst_out_beats", 64'(u_if48.out_beats), 64'd0);
        rst_n = 1'b1;
        step();
        check("post_rst_in_ready", 64'(u_if48.in_ready), 64'd1);

        // 1: single beat of eight 1s; beat in cycle 0 -> result in cycle 2
        beat48(32'd1, 8'hFF, 1'b1);
        step();
        u_if48.in_valid = 1'b0;
        check("t1_lat_not_yet", 64'(u_if48.out_valid), 64'd0);
        step();
        check("t1_valid", 64'(u_if48.out_valid), 64'd1);
        check("t1_data",  64'(u_if48.out_data),  64'd8);
        check("t1_beats", 64'(u_if48.out_beats), 64'd1);
        check("t1_sat",   64'(u_if48.out_sat),   64'd0);
        step();
        check("t1_drop_valid", 64'(u_if48.out_valid), 64'd0);
        check("t1_data_hold",  64'(u_if48.out_data),  64'd8);

        // 2: 100, -250, bubble, 50(last) -> -100
        beat48(32'd100, 8'h01, 1'b0);
        step();
        beat48(32'hFFFF_FF06, 8'h01, 1'b0);
        step();
        u_if48.in_valid = 1'b0;
        step();
        beat48(32'd50, 8'h01, 1'b1);
        step();
        u_if48.in_valid = 1'b0;
        step();
        check("t2_valid", 64'(u_if48.out_valid), 64'd1);
        check("t2_data",  64'(u_if48.out_data),  64'h0000_FFFF_FFFF_FF9C);
        check("t2_beats", 64'(u_if48.out_beats), 64'd3);
        check("t2_sat",   64'(u_if48.out_sat),   64'd0);
        step();

        // 3: masks, back-to-back single-beat dot products
        beat48(32'd5, 8'h0F, 1'b1);
        step();
        beat48(32'd5, 8'h00, 1'b1);
        step();
        u_if48.in_valid = 1'b0;
        check("t3_mask0F_valid", 64'(u_if48.out_valid), 64'd1);
        check("t3_mask0F_data",  64'(u_if48.out_data),   64'd20);
        step();
        check("t3_mask00_valid", 64'(u_if48.out_valid), 64'd1);
        check("t3_mask00_data",  64'(u_if48.out_data),   64'd0);
        check("t3_mask00_beats", 64'(u_if48.out_beats),  64'd1);
        step();
        check("t3_idle", 64'(u_if48.out_valid), 64'd0);

        // 4: ACC_W=36 positive saturation, then a clean result
        beat36(32'h7FFF_FFFF, 8'hFF, 1'b0);
        step();
        step();
        beat36(32'h7FFF_FFFF, 8'hFF, 1'b1);
        step();
        u_if36.in_valid = 1'b0;
        step();
        check("t4_valid", 64'(u_if36.out_valid), 64'd1);
        check("t4_data",  64'(u_if36.out_data),  64'h0000_0007_FFFF_FFFF);
        check("t4_sat",   64'(u_if36.out_sat),   64'd1);
        check("t4_beats", 64'(u_if36.out_beats), 64'd3);
        beat36(32'd1, 8'h01, 1'b1);
        step();
        u_if36.in_valid = 1'b0;
        step();
        check("t4_next_data", 64'(u_if36.out_data), 64'd1);
        check("t4_next_sat",  64'(u_if36.out_sat),  64'd0);
        step();

        // 5: backpressure across two results, 7 then 9
        u_if48.out_ready = 1'b0;
        beat48(32'd7, 8'h01, 1'b1);
        step();
        check("t5_ready_before", 64'(u_if48.in_ready), 64'd1);
        beat48(32'd9, 8'h01, 1'b1);
        step();
        u_if48.in_valid = 1'b0;
        check("t5_stall_valid", 64'(u_if48.out_valid), 64'd1);
        check("t5_stall_data",  64'(u_if48.out_data),  64'd7);
        check("t5_stall_ready", 64'(u_if48.in_ready),  64'd0);
        step();
        step();
        check("t5_hold_data",  64'(u_if48.out_data), 64'd7);
        check("t5_hold_ready", 64'(u_if48.in_ready), 64'd0);
        u_if48.out_ready = 1'b1;
        #1;
        check("t5_ready_release", 64'(u_if48.in_ready), 64'd1);
        step();
        check("t5_second_valid", 64'(u_if48.out_valid), 64'd1);
        check("t5_second_data",  64'(u_if48.out_data),  64'd9);
        step();
        check("t5_drained", 64'(u_if48.out_valid), 64'd0);

        // 6: reset mid-dot-product discards the partial sum
        beat48(32'd1, 8'hFF, 1'b0);
        step();
        step();
        u_if48.in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 64'(u_if48.out_valid), 64'd0);
        check("t6_rst_ready", 64'(u_if48.in_ready),  64'd0);
        step();
        rst_n = 1'b1;
        step();
        beat48(32'd3, 8'h01, 1'b1);
        step();
        u_if48.in_valid = 1'b0;
        step();
        check("t6_valid", 64'(u_if48.out_valid), 64'd1);
        check("t6_data",  64'(u_if48.out_data),  64'd3);
        check("t6_beats", 64'(u_if48.out_beats), 64'd1);
        check("t6_sat",   64'(u_if48.out_sat),   64'd0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
